// File: rtl/msg_schedule_gen_if.sv
// msg_schedule_gen_if: input and output word streams of the schedule generator.
// master = block feeder/consumer side, slave = msg_schedule_gen side.
interface msg_schedule_gen_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last
  );
endinterface

// File: rtl/msg_schedule_gen.sv
// msg_schedule_gen: SHA-256 message schedule, 16 words in, W0..W63 out.
// Ports: clk, rst_n (async low), bus (slave: in/out valid-ready streams),
// abort (sync flush, only when SCHED_ABORT_EN is defined).
module msg_schedule_gen (
  input logic clk,
  input logic rst_n,
`ifdef SCHED_ABORT_EN
  input logic abort,
`endif
  msg_schedule_gen_if.slave bus
);

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  cnt_q;
  logic [5:0]  cnt_d;
  logic [31:0] w [16];
  logic [31:0] nxt;
  logic [31:0] shift_in;
  logic        in_hs;
  logic        out_hs;
  logic        shift;
  logic        flush;

  function automatic logic [31:0] sig0(
    input logic [31:0] x
  );
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(
    input logic [31:0] x
  );
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ {10'd0, x[31:10]};
  endfunction

`ifdef SCHED_ABORT_EN
  assign flush = abort;
`else
  assign flush = 1'b0;
`endif

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = w[0];
  assign bus.out_idx   = bus.out_valid ? cnt_q : 6'd0;
  assign bus.out_last  = bus.out_valid & (cnt_q == 6'd63);

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;

  // W[t+16] from the window holding W[t]..W[t+15]
  assign nxt = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  always_comb begin
    shift_in = nxt;
    unique case (1'b1)
      bus.in_ready:  shift_in = bus.in_data;
      bus.out_valid: shift_in = nxt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          shift = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd15) begin
            state_d = EMIT;
            cnt_d   = 6'd0;
          end
        end
      end
      EMIT: begin
        if (out_hs) begin
          shift = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_d = LOAD;
            cnt_d   = 6'd0;
          end
        end
      end
    endcase
    // abort wins over any same-cycle handshake
    if (flush) begin
      state_d = LOAD;
      cnt_d   = 6'd0;
      shift   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        w[i] <= 32'd0;
      end
    end else if (flush) begin
      for (int i = 0; i < 16; i++) begin
        w[i] <= 32'd0;
      end
    end else if (shift) begin
      for (int i = 0; i < 15; i++) begin
        w[i] <= w[i+1];
      end
      w[15] <= shift_in;
    end
  end

endmodule

// File: tb/tb_msg_schedule_gen.sv
// tb_msg_schedule_gen: randomized check of msg_schedule_gen
// against a FIPS-style schedule model.
module tb_msg_schedule_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef SCHED_ABORT_EN
  logic abort = 1'b0;
`endif

  msg_schedule_gen_if bus ();

  msg_schedule_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SCHED_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got   [64];

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] req
  );
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", tag, act, req);
    end
  endtask

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // standard FIPS 180-4 indexing: W[t] from W[t-2], W[t-7], W[t-15], W[t-16]
  function automatic void model();
    logic [31:0] s0;
    logic [31:0] s1;
    for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18)
         ^ (exp_w[t-15] >> 3);
      s1 = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19)
         ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endfunction

  function automatic void load_abc();
    foreach (msg[i]) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    model();
  endfunction

  function automatic void load_rand();
    foreach (msg[i]) msg[i] = $urandom;
    model();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int gap);
    bit done;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) tick();
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      for (int c = 0; c < 40 && !done; c++) begin
        chk("early_valid", bus.out_valid, 1'b0);
        done = bus.in_ready;
        tick();
      end
      if (!done) chk("in_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
    end
  endtask

  task automatic recv(input int n, input bit stall, input bit poke);
    int          t;
    int          guard;
    bit          held;
    logic [31:0] hd;
    logic [5:0]  hi;
    int          run;
    t = 0;
    guard = 0;
    held = 1'b0;
    run = 0;
    hd = '0;
    hi = '0;
    while (t < n && guard < 2000) begin
      guard++;
      if (!bus.out_valid) begin
        chk("out_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        return;
      end
      chk("in_ready_emit", bus.in_ready, 1'b0);
      if (held) begin
        chk("stall_data", bus.out_data, hd);
        chk("stall_idx", bus.out_idx, hi);
      end
      bus.out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (run >= 6) bus.out_ready = 1'b1;
      if (poke) begin
        bus.in_valid = $urandom_range(0, 1) != 0;
        bus.in_data  = $urandom;
      end
      if (bus.out_ready) begin
        got[t] = bus.out_data;
        chk("w", bus.out_data, exp_w[t]);
        chk("idx", bus.out_idx, t);
        chk("last", bus.out_last, t == 63);
        t++;
        held = 1'b0;
        run = 0;
      end else begin
        held = 1'b1;
        hd = bus.out_data;
        hi = bus.out_idx;
        run++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (t < n) chk("out_timeout", 1'b0, 1'b1);
  endtask

  task automatic full_block(input int gap, input bit stall, input bit poke);
    send(16, gap);
    chk("valid_rise", bus.out_valid, 1'b1);
    chk("idx0", bus.out_idx, 6'd0);
    recv(64, stall, poke);
    chk("ready_back", bus.in_ready, 1'b1);
    chk("valid_drop", bus.out_valid, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_idx", bus.out_idx, 6'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_in_ready", bus.in_ready, 1'b1);
    chk("idle_out_valid", bus.out_valid, 1'b0);
    chk("idle_out_data", bus.out_data, 32'd0);
    chk("idle_out_idx", bus.out_idx, 6'd0);

    load_abc();
    full_block(0, 1'b0, 1'b0);
    chk("abc_w0", got[0], 32'h61626380);
    chk("abc_w15", got[15], 32'h00000018);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);

    for (int k = 0; k < 2; k++) begin
      load_rand();
      full_block(0, 1'b1, 1'b0);
    end

    load_rand();
    bus.out_ready = 1'b1;
    full_block(2, 1'b0, 1'b1);

    load_rand();
    send(16, 0);
    recv(30, 1'b0, 1'b0);
    chk("pre_rst_idx", bus.out_idx, 6'd30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_idx", bus.out_idx, 6'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_rand();
    full_block(0, 1'b0, 1'b0);

`ifdef SCHED_ABORT_EN
    load_abc();
    send(7, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = msg[7];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_ld_ready", bus.in_ready, 1'b1);
    chk("abort_ld_valid", bus.out_valid, 1'b0);
    full_block(0, 1'b0, 1'b0);

    load_rand();
    send(16, 0);
    recv(10, 1'b0, 1'b0);
    chk("pre_abort_idx", bus.out_idx, 6'd10);
    bus.out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_em_valid", bus.out_valid, 1'b0);
    chk("abort_em_ready", bus.in_ready, 1'b1);
    chk("abort_em_idx", bus.out_idx, 6'd0);
    load_abc();
    full_block(0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msg_schedule_gen.md
# msg_schedule_gen

SHA-256 message-schedule generator. Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input stream, then produces the 64 schedule words W0..W63 over a valid/ready output stream. It is the producer that feeds W_t to the compression round logic, which consumes words alongside the Σ0/Σ1 round functions. Expansion uses the small sigma functions:

- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3
- σ1(x) = ROTR17 ^ ROTR19 ^ SHR10

## Interface

Parameters: none. All widths are fixed by SHA-256.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a message word.
- in_ready  out  1  block can accept a word.
- in_data  in  32  message word M_i; i=0 first.
- out_valid  out  1  out_data holds W_t.
- out_ready  in  1  consumer accepts W_t.
- out_data  out  32  schedule word W_t.
- out_idx  out  6  t of the current out_data (0..63).
- out_last  out  1  high when out_idx==63.
- abort  in  1  present only with SCHED_ABORT_EN; synchronous flush.

## Operation

- Window: 16×32 shift register w[0..15]. w[0] is the oldest word.
- Counter cnt: 6 bits.
- States: LOAD and EMIT.

LOAD state:
- in_ready=1, out_valid=0.
- On each input handshake: w[i]<=w[i+1] for i=0..14, w[15]<=in_data, cnt<=cnt+1.
- On the 16th handshake (cnt==15): go to EMIT and set cnt<=0.

EMIT state:
- in_ready=0, out_valid=1, out_data=w[0], out_idx=cnt, out_last=(cnt==63).
- next = σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32. Wrap-around is silently discarded.
- On each output handshake: shift the window left by one and set w[15]<=next, cnt<=cnt+1.
- On the handshake with cnt==63: go to LOAD and set cnt<=0. Window contents are don't-care after this.
- Equivalent recurrence: W_{t+16} = σ1(W_{t+14}) + W_{t+9} + σ0(W_{t+1}) + W_t.

Boundary conditions:
- in_valid while in EMIT: ignored, because in_ready=0. The producer must hold the word.
- out_ready low in EMIT: out_data, out_idx and out_last are held stable, and the window does not shift.
- out_ready high in LOAD: no effect.
- rst_n asserted mid-block: immediate return to LOAD. Any partial load or emission is discarded.

Reset values: state=LOAD, cnt=0, w[*]=0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.

## Timing

- out_valid rises the cycle after the 16th input handshake.
- in_ready rises the cycle after the out_last handshake.
- Throughput: one word per cycle in each direction when the partner does not stall.
- A block takes a minimum of 80 cycles (16 in + 64 out). There is no overlap between blocks.
- Critical path: σ0 + σ1 + 4-input 32-bit add, all in one cycle.
- All outputs are registered or decoded directly from registers. There is no combinational path from in_valid or out_ready to any output.

## Configuration

Macro: SCHED_ABORT_EN.

Defined:
- The abort port exists.
- abort=1 at a rising edge forces state=LOAD and cnt=0, and clears w[*] to 0, in either state.
- abort has priority over a same-cycle input or output handshake; that handshake is lost.
- out_valid is 0 in the cycle after abort.

Undefined:
- The port is absent.
- Only rst_n returns the block to LOAD.

## Test plan

- Reset: hold rst_n=0 → in_ready=1, out_valid=0, out_data=0, out_idx=0. Release with no stimulus → outputs unchanged.
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, out_ready=1.
  - out_valid rises the cycle after M15.
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - All 64 words match the software model; out_last only at idx 63.
  - in_ready returns the cycle after that.
- Backpressure: toggle out_ready randomly → out_data and out_idx are stable while stalled. The sequence is identical to the unstalled run.
- Input gaps: in_valid pulsed every third cycle → identical W sequence. Driving in_valid during EMIT is never accepted.
- Mid-block reset: assert rst_n=0 at idx 30, then reload a new block → W sequence of the new block only, starting at idx 0.
- With SCHED_ABORT_EN: abort at load word 7, then reload "abc" → correct W sequence. abort coincident with the out_idx 10 handshake → out_valid=0 next cycle and state=LOAD.
